// File: rtl/stream_max_tracker_pkg.sv
// Shared types and default widths for the stream max tracker.
// Defines the tracker state encoding used by the top-level FSM.
package max_track_pkg;

    localparam int DATA_W_DEF = 2;
    localparam int LEN_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/stream_max_tracker_if.sv
// Frame control, sample stream and result handshake for the stream max tracker.
// res_index exists only when MAX_TRACK_INDEX_EN is defined.
interface stream_max_tracker_if #(
    parameter int DATA_W = 2,
    parameter int LEN_W  = 4
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              busy;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_max;
    logic [LEN_W-1:0]  res_count;
`ifdef MAX_TRACK_INDEX_EN
    logic [LEN_W-1:0]  res_index;

    modport master (
        output start, len, in_valid, in_data, res_ready,
        input  in_ready, busy, res_valid, res_max, res_count, res_index
    );
    modport slave (
        input  start, len, in_valid, in_data, res_ready,
        output in_ready, busy, res_valid, res_max, res_count, res_index
    );
`else
    modport master (
        output start, len, in_valid, in_data, res_ready,
        input  in_ready, busy, res_valid, res_max, res_count
    );
    modport slave (
        input  start, len, in_valid, in_data, res_ready,
        output in_ready, busy, res_valid, res_max, res_count
    );
`endif
endinterface

// File: rtl/stream_max_tracker_mag_gt.sv
// Unsigned magnitude comparator: gt is 1 when a is strictly greater than b.
module mag_gt #(
    parameter int DATA_W = 2
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gt
);

    assign gt = (a > b);

endmodule

// File: rtl/stream_max_tracker.sv
// Frame maximum tracker: consumes len samples and reports their maximum and count.
// Optional feature macro MAX_TRACK_INDEX_EN adds the position of the first maximum.
module stream_max_tracker
    import max_track_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    stream_max_tracker_if.slave   bus
);

    state_t            state_r;
    state_t            state_s;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  count_r;
    logic [DATA_W-1:0] max_r;
    logic              accept_s;
    logic              last_s;
    logic              gt_s;
`ifdef MAX_TRACK_INDEX_EN
    logic [LEN_W-1:0]  index_r;
`endif

    mag_gt #(.DATA_W(DATA_W)) u_mag_gt (
        .a  (bus.in_data),
        .b  (max_r),
        .gt (gt_s)
    );

    // Next-state decode and sample-accept qualification.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = (count_r == (len_r - {{(LEN_W-1){1'b0}}, 1'b1}));
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len != {LEN_W{1'b0}}) begin
                        state_s = RUN;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (bus.in_valid) begin
                    accept_s = 1'b1;
                    if (last_s) begin
                        state_s = DONE;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame registers: cleared on start so a zero-length frame reports zeros.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_r   <= {LEN_W{1'b0}};
            count_r <= {LEN_W{1'b0}};
            max_r   <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        len_r   <= bus.len;
                        count_r <= {LEN_W{1'b0}};
                        max_r   <= {DATA_W{1'b0}};
                    end
                end
                RUN: begin
                    if (accept_s) begin
                        count_r <= count_r + {{(LEN_W-1){1'b0}}, 1'b1};
                        // First sample loads unconditionally; ties keep the earlier sample.
                        if ((count_r == {LEN_W{1'b0}}) || gt_s) begin
                            max_r <= bus.in_data;
                        end
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

`ifdef MAX_TRACK_INDEX_EN
    // Index of the first maximum, updated in lockstep with max_r.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            index_r <= {LEN_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        index_r <= {LEN_W{1'b0}};
                    end
                end
                RUN: begin
                    if (accept_s && ((count_r == {LEN_W{1'b0}}) || gt_s)) begin
                        index_r <= count_r;
                    end
                end
                default: begin
                    index_r <= index_r;
                end
            endcase
        end
    end

    assign bus.res_index = index_r;
`endif

    assign bus.in_ready  = (state_r == RUN);
    assign bus.res_valid = (state_r == DONE);
    assign bus.busy      = (state_r != IDLE);
    assign bus.res_max   = max_r;
    assign bus.res_count = count_r;

endmodule

// File: tb/tb_stream_max_tracker.sv
// Directed self-checking bench for stream_max_tracker; inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_stream_max_tracker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    stream_max_tracker_if #(.DATA_W(2), .LEN_W(4)) bus ();

    stream_max_tracker #(.DATA_W(2), .LEN_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 2'd0;
    endtask

    task automatic begin_frame(input logic [3:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        tick();
        bus.start = 1'b0;
        bus.len   = 4'd0;
    endtask

    task automatic finish_frame();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b want 0", bus.res_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.res_max !== 2'd0) begin n_fail++; $display("FAIL reset_res_max got %0d want 0", bus.res_max); end
        n_checks++; if (bus.res_count !== 4'd0) begin n_fail++; $display("FAIL reset_res_count got %0d want 0", bus.res_count); end
`ifdef MAX_TRACK_INDEX_EN
        n_checks++; if (bus.res_index !== 4'd0) begin n_fail++; $display("FAIL reset_res_index got %0d want 0", bus.res_index); end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        begin_frame(4'd4);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready got %b want 1", bus.in_ready); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", bus.busy); end
        send(2'd1);
        send(2'd3);
        send(2'd2);
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %b want 0", bus.res_valid); end
        send(2'd0);
        n_checks++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL basic_res_valid got %b want 1", bus.res_valid); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_done_in_ready got %b want 0", bus.in_ready); end
        n_checks++; if (bus.res_max !== 2'd3) begin n_fail++; $display("FAIL basic_res_max got %0d want 3", bus.res_max); end
        n_checks++; if (bus.res_count !== 4'd4) begin n_fail++; $display("FAIL basic_res_count got %0d want 4", bus.res_count); end
`ifdef MAX_TRACK_INDEX_EN
        n_checks++; if (bus.res_index !== 4'd1) begin n_fail++; $display("FAIL basic_res_index got %0d want 1", bus.res_index); end
`endif
        finish_frame();
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop got %b want 0", bus.res_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle got %b want 0", bus.busy); end
        tick();
    endtask

    task automatic test_ties();
        begin_frame(4'd3);
        send(2'd2);
        send(2'd2);
        send(2'd1);
        n_checks++; if (bus.res_max !== 2'd2) begin n_fail++; $display("FAIL ties_res_max got %0d want 2", bus.res_max); end
        n_checks++; if (bus.res_count !== 4'd3) begin n_fail++; $display("FAIL ties_res_count got %0d want 3", bus.res_count); end
`ifdef MAX_TRACK_INDEX_EN
        n_checks++; if (bus.res_index !== 4'd0) begin n_fail++; $display("FAIL ties_res_index got %0d want 0", bus.res_index); end
`endif
        finish_frame();
        tick();
    endtask

    task automatic test_zero_len();
        begin_frame(4'd0);
        n_checks++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL zero_res_valid got %b want 1", bus.res_valid); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_in_ready got %b want 0", bus.in_ready); end
        n_checks++; if (bus.res_max !== 2'd0) begin n_fail++; $display("FAIL zero_res_max got %0d want 0", bus.res_max); end
        n_checks++; if (bus.res_count !== 4'd0) begin n_fail++; $display("FAIL zero_res_count got %0d want 0", bus.res_count); end
`ifdef MAX_TRACK_INDEX_EN
        n_checks++; if (bus.res_index !== 4'd0) begin n_fail++; $display("FAIL zero_res_index got %0d want 0", bus.res_index); end
`endif
        finish_frame();
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_after_in_ready got %b want 0", bus.in_ready); end
        tick();
    endtask

    task automatic test_stalls();
        begin_frame(4'd3);
        tick();
        tick();
        n_checks++; if (bus.res_count !== 4'd0) begin n_fail++; $display("FAIL stall_count0 got %0d want 0", bus.res_count); end
        send(2'd1);
        tick();
        n_checks++; if (bus.res_count !== 4'd1) begin n_fail++; $display("FAIL stall_count1 got %0d want 1", bus.res_count); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_in_ready got %b want 1", bus.in_ready); end
        send(2'd3);
        tick();
        tick();
        send(2'd2);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold_valid cyc %0d got %b want 1", i, bus.res_valid); end
            n_checks++; if (bus.res_max !== 2'd3) begin n_fail++; $display("FAIL stall_hold_max cyc %0d got %0d want 3", i, bus.res_max); end
            n_checks++; if (bus.res_count !== 4'd3) begin n_fail++; $display("FAIL stall_hold_count cyc %0d got %0d want 3", i, bus.res_count); end
            tick();
        end
`ifdef MAX_TRACK_INDEX_EN
        n_checks++; if (bus.res_index !== 4'd1) begin n_fail++; $display("FAIL stall_res_index got %0d want 1", bus.res_index); end
`endif
        finish_frame();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stall_idle got %b want 0", bus.busy); end
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid_drop got %b want 0", bus.res_valid); end
        tick();
    endtask

    task automatic test_robustness();
        // start held high through RUN and the DONE handshake must be ignored
        begin_frame(4'd2);
        bus.start = 1'b1;
        bus.len   = 4'd5;
        send(2'd2);
        send(2'd1);
        n_checks++; if (bus.res_count !== 4'd2) begin n_fail++; $display("FAIL robust_count got %0d want 2", bus.res_count); end
        n_checks++; if (bus.res_max !== 2'd2) begin n_fail++; $display("FAIL robust_max got %0d want 2", bus.res_max); end
        tick();
        n_checks++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL robust_done_hold got %b want 1", bus.res_valid); end
        finish_frame();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL robust_start_in_done got busy %b want 0", bus.busy); end
        bus.start = 1'b0;
        bus.len   = 4'd0;
        tick();
        // reset mid-frame aborts without a result
        begin_frame(4'd4);
        send(2'd0);
        send(2'd2);
        rst_n = 1'b0;
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL abort_res_valid got %b want 0", bus.res_valid); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL abort_after_valid got %b want 0", bus.res_valid); end
        begin_frame(4'd2);
        send(2'd0);
        send(2'd1);
        n_checks++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL refill_valid got %b want 1", bus.res_valid); end
        n_checks++; if (bus.res_max !== 2'd1) begin n_fail++; $display("FAIL refill_max got %0d want 1", bus.res_max); end
        n_checks++; if (bus.res_count !== 4'd2) begin n_fail++; $display("FAIL refill_count got %0d want 2", bus.res_count); end
`ifdef MAX_TRACK_INDEX_EN
        n_checks++; if (bus.res_index !== 4'd1) begin n_fail++; $display("FAIL refill_index got %0d want 1", bus.res_index); end
`endif
        finish_frame();
        tick();
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.len       = 4'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 2'd0;
        bus.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_ties();
        test_zero_len();
        test_stalls();
        test_robustness();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
